// File: rtl/mcp3008_sampler_if.sv
// Pin and result bundle between the MCP3008 sampler and its neighbours.
// master: the sampler itself; slave: the ADC pins' far side plus the sample consumer.
interface mcp3008_sampler_if;
  logic       start;
  logic [2:0] channel;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic       adc_din;
  logic       adc_dout;
  logic       busy;
  logic [9:0] sample;
  logic       sample_valid;
  logic [2:0] sample_chan;
  logic       null_err;

  modport master (
    input  start, channel, adc_dout,
    output adc_sclk, adc_cs_n, adc_din, busy, sample, sample_valid, sample_chan, null_err
  );

  modport slave (
    output start, channel, adc_dout,
    input  adc_sclk, adc_cs_n, adc_din, busy, sample, sample_valid, sample_chan, null_err
  );
endinterface

// File: rtl/mcp3008_sampler.sv
// SPI master running single-ended MCP3008 conversions; SCLK/CS_n/DIN are registered
// outputs paced by a clock-enable divider, results delivered with a one-clk strobe.
module mcp3008_sampler #(
  parameter int unsigned CLK_DIV = 1350,
  parameter int unsigned CS_IDLE = 4,
  parameter bit          AUTO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mcp3008_sampler_if.master bus
);

  localparam int unsigned FrameHalves = 34;
  localparam int unsigned GapHalves   = 2 * CS_IDLE;
  localparam int unsigned DivW        = $clog2(CLK_DIV);
  localparam int unsigned HalfW       = $clog2(FrameHalves + GapHalves);

  localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [HalfW-1:0] NullHalf  = HalfW'(12);
  localparam logic [HalfW-1:0] FrameLast = HalfW'(FrameHalves - 1);
  localparam logic [HalfW-1:0] GapLast   = HalfW'(GapHalves - 1);

  typedef enum logic [1:0] {StIdle, StFrame, StDone, StGap} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [HalfW-1:0] half_q, half_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic [9:0]       shift_q, shift_d;
  logic [2:0]       chan_q, chan_d;
  logic [9:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
  logic [2:0]       schan_q, schan_d;
  logic             null_q, null_d;
  logic             tick;

  assign tick = (div_q == DivLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      half_q   <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      shift_q  <= '0;
      chan_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      schan_q  <= '0;
      null_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      chan_q   <= chan_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      schan_q  <= schan_d;
      null_q   <= null_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    din_d    = din_q;
    busy_d   = busy_q;
    shift_d  = shift_q;
    chan_d   = chan_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    schan_d  = schan_q;
    null_d   = null_q;

    if (state_q == StFrame || state_q == StGap) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (AUTO || bus.start) begin
          state_d = StFrame;
          div_d   = '0;
          half_d  = '0;
          chan_d  = bus.channel;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          din_d   = 1'b1;
          sclk_d  = 1'b0;
        end
      end
      StFrame: begin
        if (tick) begin
          half_d = half_q + HalfW'(1);
          if (!half_q[0]) begin
            // Even half count: this tick ends a low half, so it is a rising edge.
            sclk_d = 1'b1;
            if (half_q == NullHalf) begin
              null_d = null_q | bus.adc_dout;
            end else if (half_q > NullHalf) begin
              shift_d = {shift_q[8:0], bus.adc_dout};
            end
          end else begin
            sclk_d = 1'b0;
            // Command bit for the period whose low half starts now.
            case (half_q)
              HalfW'(1): din_d = 1'b1;
              HalfW'(3): din_d = chan_q[2];
              HalfW'(5): din_d = chan_q[1];
              HalfW'(7): din_d = chan_q[0];
              default:   din_d = 1'b0;
            endcase
            if (half_q == FrameLast) begin
              state_d = StDone;
              cs_n_d  = 1'b1;
              half_d  = '0;
            end
          end
        end
      end
      StDone: begin
        sample_d = shift_q;
        schan_d  = chan_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = StGap;
      end
      StGap: begin
        if (tick) begin
          half_d = half_q + HalfW'(1);
          if (half_q == GapLast) begin
            state_d = StIdle;
            half_d  = '0;
          end
        end
      end
    endcase
  end

  assign bus.adc_sclk     = sclk_q;
  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_din      = din_q;
  assign bus.busy         = busy_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_chan  = schan_q;
  assign bus.null_err     = null_q;

endmodule

// File: tb/tb_mcp3008_sampler.sv
// Bench for mcp3008_sampler: an ADC pin model plus a frame-level reference model for a
// start-driven instance (index 0) and a free-running instance (index 1).
module tb_mcp3008_sampler;

  localparam int CD         = 2;
  localparam int CSI        = 4;
  localparam int FRAME_CLKS = 17 * 2 * CD;
  localparam int VALID_LAT  = FRAME_CLKS + 1;
  localparam int PERIOD     = (17 + CSI) * 2 * CD + 2;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  mcp3008_sampler_if if0 ();
  mcp3008_sampler_if if1 ();

  mcp3008_sampler #(.CLK_DIV(CD), .CS_IDLE(CSI), .AUTO(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0)
  );
  mcp3008_sampler #(.CLK_DIV(CD), .CS_IDLE(CSI), .AUTO(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ADC pin model: drives the bit for the period whose low half just began.
  logic [9:0] a_val [2] = '{10'h000, 10'h155};
  logic       a_nul [2] = '{1'b0, 1'b0};
  int         rises [2] = '{0, 0};
  int         last_rises [2] = '{0, 0};
  logic [4:0] din_rec [2] = '{5'd0, 5'd0};
  logic       sclk_p [2] = '{1'b0, 1'b0};
  logic       cs_p [2] = '{1'b1, 1'b1};
  logic       dout_v [2] = '{1'b0, 1'b0};
  logic       asc_v [2], acs_v [2], adin_v [2];

  function automatic logic adc_bit(input int r, input logic [9:0] v, input logic nul);
    int p;
    p = r + 1;
    if (p == 7) return nul;
    if (p >= 8 && p <= 17) return v[17 - p];
    return 1'b0;
  endfunction

  initial begin
    if0.adc_dout = 1'b0;
    if1.adc_dout = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    asc_v[0] = if0.adc_sclk; acs_v[0] = if0.adc_cs_n; adin_v[0] = if0.adc_din;
    asc_v[1] = if1.adc_sclk; acs_v[1] = if1.adc_cs_n; adin_v[1] = if1.adc_din;
    for (int k = 0; k < 2; k++) begin
      if (acs_v[k]) begin
        if (!cs_p[k]) last_rises[k] = rises[k];
        rises[k]  = 0;
        dout_v[k] = 1'b0;
      end else if (asc_v[k] && !sclk_p[k]) begin
        if (rises[k] < 5) din_rec[k][4-rises[k]] = adin_v[k];
        rises[k]++;
      end else if (!asc_v[k] && sclk_p[k]) begin
        dout_v[k] = adc_bit(rises[k], a_val[k], a_nul[k]);
      end
      sclk_p[k] = asc_v[k];
      cs_p[k]   = acs_v[k];
    end
    if0.adc_dout = dout_v[0];
    if1.adc_dout = dout_v[1];
  end

  // Frame-level reference model and per-cycle compare.
  int         start_c [2] = '{0, 0};
  int         ready [2] = '{0, 0};
  int         cs_hi [2] = '{0, 0};
  int         n_launch [2] = '{0, 0};
  logic       pend [2] = '{1'b0, 1'b0};
  logic       m_null [2], f_nul [2];
  logic [9:0] m_sample [2], f_val [2];
  logic [2:0] m_chan [2], f_chan [2];
  logic       cs_q [2] = '{1'b1, 1'b1};
  logic       rst_v [2], cs_v [2], sc_v [2], va_v [2], nu_v [2], bu_v [2], st_v [2];
  logic [9:0] sm_v [2];
  logic [2:0] ch_o [2], chi_v [2];
  logic       launch, exp_launch, exp_valid, exp_sclk, exp_cs_n;

  always @(posedge clk) begin
    #1;
    cyc++;
    rst_v[0] = rst0; cs_v[0] = if0.adc_cs_n; sc_v[0] = if0.adc_sclk; va_v[0] = if0.sample_valid;
    nu_v[0] = if0.null_err; bu_v[0] = if0.busy; sm_v[0] = if0.sample; ch_o[0] = if0.sample_chan;
    st_v[0] = if0.start; chi_v[0] = if0.channel;
    rst_v[1] = rst1; cs_v[1] = if1.adc_cs_n; sc_v[1] = if1.adc_sclk; va_v[1] = if1.sample_valid;
    nu_v[1] = if1.null_err; bu_v[1] = if1.busy; sm_v[1] = if1.sample; ch_o[1] = if1.sample_chan;
    st_v[1] = 1'b1; chi_v[1] = if1.channel;
    for (int k = 0; k < 2; k++) begin
      exp_valid = 1'b0;
      launch    = cs_q[k] && !cs_v[k];
      if (rst_v[k]) begin
        m_sample[k] = '0; m_chan[k] = '0; m_null[k] = 1'b0;
        pend[k] = 1'b0; ready[k] = cyc + 1; cs_hi[k] = 0; n_launch[k] = 0;
      end else begin
        exp_launch = !pend[k] && (cyc >= ready[k]) && st_v[k];
        chk(k ? "a_launch" : "m_launch", launch, exp_launch);
        if (exp_launch) begin
          if (k == 1 && n_launch[1] > 0) chk("a_cs_gap", cs_hi[1] >= 16, 1);
          start_c[k] = cyc; pend[k] = 1'b1; n_launch[k]++;
          f_chan[k] = chi_v[k]; f_val[k] = a_val[k]; f_nul[k] = a_nul[k];
        end
        if (pend[k] && cyc == start_c[k] + 13 * CD) m_null[k] = m_null[k] | f_nul[k];
        exp_valid = pend[k] && (cyc == start_c[k] + VALID_LAT);
        if (exp_valid) begin
          m_sample[k] = f_val[k]; m_chan[k] = f_chan[k]; pend[k] = 1'b0;
          ready[k] = start_c[k] + PERIOD;
          chk(k ? "a_rises" : "m_rises", last_rises[k], 17);
          chk(k ? "a_din" : "m_din", din_rec[k], {2'b11, f_chan[k]});
        end
      end
      exp_cs_n = !(pend[k] && cyc < start_c[k] + FRAME_CLKS);
      exp_sclk = pend[k] && cyc < start_c[k] + FRAME_CLKS && (((cyc - start_c[k]) / CD) % 2 == 1);
      chk(k ? "a_valid" : "m_valid", va_v[k], exp_valid);
      chk(k ? "a_sample" : "m_sample", sm_v[k], m_sample[k]);
      chk(k ? "a_chan" : "m_chan", ch_o[k], m_chan[k]);
      chk(k ? "a_null" : "m_null", nu_v[k], m_null[k]);
      chk(k ? "a_busy" : "m_busy", bu_v[k], pend[k]);
      chk(k ? "a_cs_n" : "m_cs_n", cs_v[k], exp_cs_n);
      chk(k ? "a_sclk" : "m_sclk", sc_v[k], exp_sclk);
      cs_hi[k] = cs_v[k] ? cs_hi[k] + 1 : 0;
      cs_q[k]  = cs_v[k];
    end
  end

  // Start-driven instance helpers.
  task automatic kick(input logic [2:0] ch, input logic [9:0] v, input logic nul);
    repeat (20) @(negedge clk);
    if0.channel = ch; a_val[0] = v; a_nul[0] = nul; if0.start = 1'b1;
    @(posedge clk); #2;
    chk("entry_cs_n", if0.adc_cs_n, 0);
    chk("entry_busy", if0.busy, 1);
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #2;
      lat++;
      if (if0.sample_valid) break;
    end
  endtask

  logic [9:0] au_val [3] = '{10'h155, 10'h0AA, 10'h1C3};
  logic [2:0] au_ch [3] = '{3'd2, 3'd5, 3'd6};
  logic [2:0] au_junk [3] = '{3'd7, 3'd0, 3'd1};

  initial begin
    int lat, nv, t_prev;
    logic got;
    if0.start = 1'b0; if0.channel = 3'd0;
    if1.start = 1'b0; if1.channel = au_ch[0];
    repeat (3) @(negedge clk);
    rst0 = 1'b0;

    nv = 0;
    repeat (100) begin @(posedge clk); #2; if (if0.sample_valid) nv++; end
    chk("idle_cs_n", if0.adc_cs_n, 1);
    chk("idle_sclk", if0.adc_sclk, 0);
    chk("idle_busy", if0.busy, 0);
    chk("idle_sample", if0.sample, 0);
    chk("idle_valids", nv, 0);

    // Abort during SCLK period 10.
    kick(3'd5, 10'h1F0, 1'b0);
    repeat (36) @(negedge clk);
    rst0 = 1'b1;
    #1;
    chk("abort_cs_n", if0.adc_cs_n, 1);
    chk("abort_busy", if0.busy, 0);
    chk("abort_valid", if0.sample_valid, 0);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    nv = 0;
    repeat (100) begin @(posedge clk); #2; if (if0.sample_valid) nv++; end
    chk("abort_valids", nv, 0);
    chk("abort_sample", if0.sample, 0);

    kick(3'd3, 10'h2A5, 1'b0);
    if0.channel = 3'd6;
    wait_valid(lat);
    chk("single_latency", lat, 69);
    chk("single_sample", if0.sample, 10'h2A5);
    chk("single_chan", if0.sample_chan, 3);
    chk("single_din", din_rec[0], 5'b11011);
    chk("single_rises", last_rises[0], 17);

    kick(3'd1, 10'h000, 1'b0);
    wait_valid(lat);
    chk("zero_sample", if0.sample, 10'h000);
    @(negedge clk); if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    kick(3'd7, 10'h3FF, 1'b0);
    wait_valid(lat);
    chk("full_sample", if0.sample, 10'h3FF);
    chk("full_chan", if0.sample_chan, 7);
    chk("full_null", if0.null_err, 0);

    @(negedge clk); if0.channel = 3'd4; a_val[0] = 10'h0C3; if0.start = 1'b1;
    repeat (200) @(negedge clk);
    if0.start = 1'b0;
    repeat (100) @(negedge clk);

    kick(3'd2, 10'h0F0, 1'b1);
    wait_valid(lat);
    chk("nerr_set", if0.null_err, 1);
    chk("nerr_sample", if0.sample, 10'h0F0);
    kick(3'd4, 10'h00F, 1'b0);
    wait_valid(lat);
    chk("nerr_sticky", if0.null_err, 1);
    chk("nerr_sample2", if0.sample, 10'h00F);
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    chk("nerr_cleared", if0.null_err, 0);

    // Free-running instance: three frames, channel disturbed mid-frame.
    @(negedge clk); rst1 = 1'b0;
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(posedge clk); #2;
        got = if1.sample_valid;
        if (i == 30) if1.channel = au_junk[f];
      end
      chk("auto_valid_seen", got, 1);
      chk("auto_chan", if1.sample_chan, au_ch[f]);
      chk("auto_sample", if1.sample, au_val[f]);
      chk("auto_null", if1.null_err, 0);
      if (f > 0) chk("auto_period", cyc - t_prev, 86);
      t_prev = cyc;
      if (f < 2) begin
        a_val[1] = au_val[f+1];
        if1.channel = au_ch[f+1];
      end
    end
    @(negedge clk); rst1 = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
